// File: rtl/bilinear_upsampler_2x_pkg.sv
// Shared definitions for the 2x bilinear upscaler and the downstream 2x writer.
// Both sides use the lane constants so they agree on where each output pixel sits.
package bilinear_upsampler_2x_pkg;

    localparam int PW_DEF    = 8;
    localparam int WI_DEF    = 32;
    localparam int NUM_LANES = 4;

    localparam int LANE_TL = 0;
    localparam int LANE_TR = 1;
    localparam int LANE_BL = 2;
    localparam int LANE_BR = 3;

    function automatic int lane_lsb(input int lane, input int pw);
        return lane * pw;
    endfunction

endpackage

// File: rtl/upsample_line_buffer.sv
// One line of previous-row pixels: single port, read-before-write, registered read.
// The array is deliberately not reset; row 0 never consumes its contents.
module upsample_line_buffer
    import bilinear_upsampler_2x_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int PW    = PW_DEF,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [PW-1:0] i_wdata,
    output logic [PW-1:0] o_rdata
);

    logic [PW-1:0] r_mem [WIDTH];
    logic [PW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bilinear_upsampler_2x.sv
// Streaming 2x bilinear upscaler: each input pixel yields one packed 2x2 block,
// using only the current pixel, its left neighbour and the two pixels above.
module bilinear_upsampler_2x
    import bilinear_upsampler_2x_pkg::*;
#(
    parameter int WI     = WI_DEF,
    parameter int PW     = PW_DEF,
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] din,
    input  logic          vld_i,
    output logic [WI-1:0] dout,
    output logic          vld_o,
    output logic          eol_o,
    output logic          eof_o
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    function automatic logic [PW-1:0] avg2(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW:0] s;
        s = {1'b0, x} + {1'b0, y} + (PW+1)'(1);
        return s[PW:1];
    endfunction

    function automatic logic [PW-1:0] avg4(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c, input logic [PW-1:0] d);
        logic [PW+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + (PW+2)'(2);
        return s[PW+1:2];
    endfunction

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_s0_vld;
    logic [CW-1:0] r_s0_col;
    logic [RW-1:0] r_s0_row;
    logic [PW-1:0] r_c;
    logic [PW-1:0] r_l;
    logic [PW-1:0] r_d;

    logic          w_wr_en;
    logic [PW-1:0] w_a_raw;
    logic          w_first_col;
    logic          w_first_row;
    logic [PW-1:0] w_a;
    logic [PW-1:0] w_l;
    logic [PW-1:0] w_d;
    logic [PW-1:0] w_lane [NUM_LANES];
    logic [WI-1:0] w_dout_next;

    // Raster position of the pixel arriving this cycle; line and frame wrap together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (vld_i) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign w_wr_en = vld_i & ~rst;

    upsample_line_buffer #(
        .WIDTH (WIDTH),
        .PW    (PW),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .i_en    (w_wr_en),
        .i_addr  (r_col),
        .i_wdata (din),
        .o_rdata (w_a_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            r_c      <= din;
            r_s0_col <= r_col;
            r_s0_row <= r_row;
        end
    end

    // Edge replication: missing neighbours fall back to the nearest real pixel.
    assign w_first_col = (r_s0_col == '0);
    assign w_first_row = (r_s0_row == '0);
    assign w_a = w_first_row ? r_c : w_a_raw;
    assign w_l = w_first_col ? r_c : r_l;
    assign w_d = w_first_col ? w_a : (w_first_row ? r_l : r_d);

    assign w_lane[LANE_TL] = avg4(r_c, w_l, w_a, w_d);
    assign w_lane[LANE_TR] = avg2(w_a, r_c);
    assign w_lane[LANE_BL] = avg2(w_l, r_c);
    assign w_lane[LANE_BR] = r_c;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pack
            assign w_dout_next[lane_lsb(gi, PW) +: PW] = w_lane[gi];
        end
    endgenerate

    // Left and upper-left neighbours for the next pixel; they hold across input gaps.
    always_ff @(posedge clk) begin
        if (r_s0_vld) begin
            r_l <= r_c;
            r_d <= w_a_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            vld_o <= 1'b0;
            eol_o <= 1'b0;
            eof_o <= 1'b0;
        end else begin
            vld_o <= r_s0_vld;
            eol_o <= r_s0_vld & (r_s0_col == COL_LAST);
            eof_o <= r_s0_vld & (r_s0_col == COL_LAST) & (r_s0_row == ROW_LAST);
            if (r_s0_vld) begin
                dout <= w_dout_next;
            end
        end
    end

endmodule
